// File: rtl/mvm_read_seq.sv
// rtl/mvm_read_seq.sv - read-side sequencer and MAC for the matrix-vector engine
// Walks mem_M/mem_X row by row, accumulates each dot product, streams y[i] out.
module mvm_read_seq #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16,
  parameter int ROWS   = 3,
  parameter int COLS   = 3,
  localparam int AM_W  = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1,
  localparam int AX_W  = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int IW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] rd_data_M,
  input  logic [DATA_W-1:0] rd_data_X,
  output logic [AM_W-1:0]   addr_M,
  output logic [AX_W-1:0]   addr_X,
  output logic              rd_en_M,
  output logic              rd_en_X,
  output logic [OUT_W-1:0]  data_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, READ, WAIT, OUT} state_t;

  state_t                    state_q, state_d;
  logic [IW-1:0]             i_q;
  logic [AX_W-1:0]           j_q;
  logic signed [OUT_W-1:0]   acc_q;
  logic                      rd_q;
  logic                      done_q;
  logic                      clr_acc;
  logic                      done_d;
  logic                      rd_en;
  logic                      row_next;
  logic                      col_last;
  logic                      row_last;
  logic signed [2*DATA_W-1:0] prod;

  assign col_last = (j_q == AX_W'(COLS - 1));
  assign row_last = (i_q == IW'(ROWS - 1));
  assign prod     = $signed(rd_data_M) * $signed(rd_data_X);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    clr_acc  = 1'b0;
    done_d   = 1'b0;
    row_next = 1'b0;
    rd_en    = 1'b0;
    m_valid  = 1'b0;
    addr_M   = '0;
    addr_X   = '0;
    data_out = '0;
    busy     = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          clr_acc = 1'b1;
        end
      end
      READ: begin
        rd_en  = 1'b1;
        addr_M = AM_W'(i_q) * AM_W'(COLS) + AM_W'(j_q);
        addr_X = j_q;
        if (col_last) state_d = WAIT;
      end
      WAIT: state_d = OUT;
      OUT: begin
        m_valid  = 1'b1;
        data_out = acc_q;
        if (m_ready) begin
          if (row_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d  = READ;
            clr_acc  = 1'b1;
            row_next = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_en_M = rd_en;
  assign rd_en_X = rd_en;
  assign done    = done_q;

  // rd_q marks the cycle in which the memory returns data for last cycle's read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_q    <= '0;
      j_q    <= '0;
      acc_q  <= '0;
      rd_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rd_q   <= rd_en;
      done_q <= done_d;
      if (rd_en) j_q <= col_last ? '0 : j_q + 1'b1;
      if (row_next)    i_q <= i_q + 1'b1;
      else if (done_d) i_q <= '0;
      else if (state_q == IDLE && start) i_q <= '0;
      if (clr_acc)   acc_q <= '0;
      else if (rd_q) acc_q <= acc_q + OUT_W'(prod);
    end
  end

endmodule

// File: tb/tb_mvm_read_seq.sv
// tb/tb_mvm_read_seq.sv - self-checking bench for mvm_read_seq
// Table vectors plus random matrices checked against a dot-product model.
module tb_mvm_read_seq;

  localparam int ROWS = 3;
  localparam int COLS = 3;

  typedef struct {
    logic [ROWS*COLS-1:0][7:0] m;
    logic [COLS-1:0][7:0]      x;
    logic [ROWS-1:0][15:0]     y;
    int                        stall;
    bit                        mid;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rd_data_M;
  logic [7:0]  rd_data_X;
  logic [3:0]  addr_M;
  logic [1:0]  addr_X;
  logic        rd_en_M;
  logic        rd_en_X;
  logic [15:0] data_out;
  logic        m_valid;
  logic        m_ready;
  logic        busy;
  logic        done;

  logic [7:0] mem_m [ROWS*COLS];
  logic [7:0] mem_x [COLS];

  int checks = 0;
  int errors = 0;
  int rd_cnt, done_cnt, busy_gap;
  vec_t tab [6];
  vec_t rv;

  mvm_read_seq dut (
    .clk(clk), .reset(reset), .start(start),
    .rd_data_M(rd_data_M), .rd_data_X(rd_data_X),
    .addr_M(addr_M), .addr_X(addr_X),
    .rd_en_M(rd_en_M), .rd_en_X(rd_en_X),
    .data_out(data_out), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // synchronous-read memories: data appears the cycle after the enable
  always @(posedge clk) begin
    if (rd_en_M) rd_data_M <= mem_m[addr_M];
    if (rd_en_X) rd_data_X <= mem_x[addr_X];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    rd_cnt   += int'(rd_en_M);
    done_cnt += int'(done);
  endtask

  function automatic logic [15:0] ref_y(input vec_t v, input int r);
    int s = 0;
    for (int j = 0; j < COLS; j++)
      s += int'($signed(v.m[r*COLS+j])) * int'($signed(v.x[j]));
    return 16'(s);
  endfunction

  task automatic all_zero(input string name);
    chk(name, {addr_M, addr_X, rd_en_M, rd_en_X, data_out, m_valid, busy, done}, 32'h0);
  endtask

  task automatic abort_run(input string name);
    #2 reset = 1'b1;
    #1 all_zero(name);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input bit hold_start);
    int cyc;
    for (int n = 0; n < ROWS*COLS; n++) mem_m[n] = v.m[n];
    for (int n = 0; n < COLS; n++) mem_x[n] = v.x[n];
    rd_cnt = 0; done_cnt = 0; busy_gap = 0;
    m_ready = (v.stall == 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      cyc = 1;
      if (!busy) busy_gap++;
      while (!m_valid && cyc < 40) begin
        start = v.mid && (cyc == 2);
        tick();
        cyc++;
        if (!busy) busy_gap++;
      end
      start = 1'b0;
      chk("latency", cyc, 5);
      for (int s = 0; s < v.stall; s++) begin
        chk("stall_hold", {m_valid, data_out}, {1'b1, v.y[r]});
        tick();
        if (!busy) busy_gap++;
      end
      chk("data_out", {m_valid, data_out}, {1'b1, v.y[r]});
      m_ready = 1'b1;
      if (r == ROWS - 1 && hold_start) start = 1'b1;
      tick();
      m_ready = (v.stall == 0);
    end
    chk("done_pulse", {done, busy}, {1'b1, 1'b0});
    chk("rd_count", rd_cnt, ROWS*COLS);
    chk("busy_gap", busy_gap, 0);
    if (hold_start) begin
      tick();
      start = 1'b0;
      chk("b2b_restart", {busy, rd_en_M}, 2'b11);
    end else begin
      tick();
      chk("done_count", {done, 31'(done_cnt)}, 32'd1);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; m_ready = 1'b0;
    rd_data_M = '0; rd_data_X = '0;
    for (int n = 0; n < ROWS*COLS; n++) mem_m[n] = '0;
    for (int n = 0; n < COLS; n++) mem_x[n] = '0;
    #1 all_zero("reset_state");
    @(negedge clk);
    @(negedge clk);
    all_zero("reset_hold");
    reset = 1'b0;
    @(negedge clk);
    all_zero("idle_after_reset");

    for (int k = 0; k < 6; k++) begin
      tab[k].stall = 0;
      tab[k].mid   = 1'b0;
    end
    for (int n = 0; n < 9; n++) begin
      tab[0].m[n] = (n % 4 == 0) ? 8'd1 : 8'd0;
      tab[1].m[n] = 8'(n + 1);
      tab[3].m[n] = 8'hFF;
      tab[4].m[n] = 8'h7F;
    end
    for (int n = 0; n < 3; n++) begin
      tab[0].x[n] = 8'(n + 1);
      tab[1].x[n] = 8'd1;
      tab[3].x[n] = 8'(n + 2);
      tab[4].x[n] = 8'h7F;
      tab[0].y[n] = 16'(n + 1);
      tab[3].y[n] = 16'hFFF7;
      tab[4].y[n] = 16'hBD03;
    end
    tab[1].y[0] = 16'd6; tab[1].y[1] = 16'd15; tab[1].y[2] = 16'd24;
    tab[2] = tab[1];
    tab[2].stall = 4;
    tab[5] = tab[1];
    tab[5].mid = 1'b1;

    for (int k = 0; k < 6; k++) run_vec(tab[k], 1'b0);

    for (int k = 0; k < 8; k++) begin
      for (int n = 0; n < 9; n++) rv.m[n] = 8'($urandom);
      for (int n = 0; n < 3; n++) rv.x[n] = 8'($urandom);
      for (int r = 0; r < 3; r++) rv.y[r] = ref_y(rv, r);
      rv.stall = int'($urandom_range(0, 3));
      rv.mid   = 1'($urandom);
      run_vec(rv, 1'b0);
    end

    // back-to-back start on the done edge, then abort the new run
    run_vec(tab[4], 1'b1);
    abort_run("abort_b2b");

    // reset while reading row 1, then a clean rerun
    for (int n = 0; n < 9; n++) mem_m[n] = tab[1].m[n];
    for (int n = 0; n < 3; n++) mem_x[n] = tab[1].x[n];
    m_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    chk("row1_reading", {busy, rd_en_M, addr_M}, {1'b1, 1'b1, 4'd4});
    abort_run("abort_row1");
    for (int c = 0; c < 3; c++) begin
      tick();
      all_zero("idle_after_abort");
    end
    run_vec(tab[1], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
